// File: rtl/io_port.sv
// rtl/io_port.sv - memory-mapped CPU I/O port with TX and RX byte FIFOs
module io_port #(
   parameter logic [7:0] BASE_ADDR = 8'hF0,
   parameter int         DEPTH     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   input  logic       set,
   input  logic       get,
   output logic       hit,
   output logic [7:0] rdata,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [7:0]    tx_mem [DEPTH];
   logic [7:0]    rx_mem [DEPTH];
   logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
   logic [CW-1:0] tx_cnt, rx_cnt;
   logic          ovf, udf;

   logic tx_full, tx_empty, rx_full, rx_empty;
   logic cpu_tx_wr, cpu_rx_rd, ctrl_wr;
   logic tx_push, tx_pop, rx_push, rx_pop;
   logic ovf_evt, udf_evt, clr, flush;
   logic [7:0] status;

   assign tx_full  = (tx_cnt == FULL_CNT);
   assign tx_empty = (tx_cnt == '0);
   assign rx_full  = (rx_cnt == FULL_CNT);
   assign rx_empty = (rx_cnt == '0);

   assign hit       = (addr[7:2] == BASE_ADDR[7:2]);
   assign cpu_tx_wr = set && hit && (addr[1:0] == 2'd0);
   assign cpu_rx_rd = get && hit && (addr[1:0] == 2'd1);
   assign ctrl_wr   = set && hit && (addr[1:0] == 2'd3);
   assign clr       = ctrl_wr && wdata[0];
   assign flush     = ctrl_wr && wdata[1];

   // Every push/pop decision sees the occupancy from before this edge.
   assign tx_push = cpu_tx_wr && !tx_full;
   assign ovf_evt = cpu_tx_wr && tx_full;
   assign tx_pop  = tx_valid && tx_ready;
   assign rx_push = rx_valid && rx_ready;
   assign rx_pop  = cpu_rx_rd && !rx_empty;
   assign udf_evt = cpu_rx_rd && rx_empty;

   assign tx_valid = !tx_empty;
   assign tx_data  = tx_mem[tx_rp];
   assign rx_ready = !rx_full;

   assign status = {2'b00, udf, ovf, rx_full, !rx_empty, tx_empty, tx_full};

   always_comb begin
      rdata = 8'h00;
      if (hit) begin
         case (addr[1:0])
            2'd1:    rdata = rx_empty ? 8'h00 : rx_mem[rx_rp];
            2'd2:    rdata = status;
            default: rdata = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            tx_mem[i] <= 8'h00;
            rx_mem[i] <= 8'h00;
         end
         tx_wp  <= '0;
         tx_rp  <= '0;
         rx_wp  <= '0;
         rx_rp  <= '0;
         tx_cnt <= '0;
         rx_cnt <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         if (tx_push) tx_mem[tx_wp] <= wdata;
         if (rx_push) rx_mem[rx_wp] <= rx_data;

         // Flush only resets bookkeeping; stale contents stay unreadable.
         if (flush) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            tx_cnt <= '0;
            rx_cnt <= '0;
         end else begin
            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + AW'(1);
            if (rx_push) rx_wp <= rx_wp + AW'(1);
            if (rx_pop)  rx_rp <= rx_rp + AW'(1);
            tx_cnt <= tx_cnt + {{AW{1'b0}}, tx_push} - {{AW{1'b0}}, tx_pop};
            rx_cnt <= rx_cnt + {{AW{1'b0}}, rx_push} - {{AW{1'b0}}, rx_pop};
         end

         if (clr)          ovf <= 1'b0;
         else if (ovf_evt) ovf <= 1'b1;
         if (clr)          udf <= 1'b0;
         else if (udf_evt) udf <= 1'b1;
      end
   end

endmodule

// File: doc/io_port.md
# io_port

Memory-mapped I/O responder on the CPU's 8-bit data bus. Answers CPU read and write strobes in a 4-byte address window that it decodes from the MAR value. Behind the window it buffers bytes in two FIFOs:
- a TX FIFO, filled by CPU stores and drained by an external host;
- an RX FIFO, filled by the host and drained by CPU loads.

It sits beside the RAM as the responder end of the CPU's memory-access protocol. CPU-side tristate enabling is done by the caller, using `hit`.

## Interface
Parameters:
- BASE_ADDR, 8'hF0, first address of the window (low 2 bits must be 0)
- DEPTH, 4, entries per FIFO (power of two, 2..16)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous active-low reset
- addr  in  8  access address (MAR output)
- wdata  in  8  write data (bus)
- set  in  1  CPU write strobe, one cycle per store
- get  in  1  CPU read-acknowledge strobe, one cycle per load, asserted in the cycle the CPU samples rdata
- hit  out  1  combinational: addr[7:2] == BASE_ADDR[7:2]
- rdata  out  8  combinational read data for addr (0 when !hit)
- tx_data  out  8  head of TX FIFO
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  host accepts tx_data when tx_valid && tx_ready
- rx_data  in  8  host byte for RX FIFO
- rx_valid  in  1  host offers rx_data
- rx_ready  out  1  RX FIFO not full

## Operation
Register map (offset = addr[1:0]):
- 0 TXDATA
  - write pushes wdata into the TX FIFO.
  - If the FIFO is full, the byte is dropped and the sticky OVF flag is set.
  - Reads return 0.
- 1 RXDATA
  - Read returns the RX head, or 0 if empty.
  - `get` pops the head.
  - `get` while empty sets the sticky UDF flag and changes nothing else.
  - Writes are ignored.
- 2 STATUS (read-only)
  - bit0 tx_full, bit1 tx_empty, bit2 rx_nonempty, bit3 rx_full, bit4 OVF, bit5 UDF, bits7:6 = 0.
- 3 CTRL (write-only, reads 0)
  - bit0 = 1 clears OVF and UDF.
  - bit1 = 1 flushes both FIFOs (pointers and counts to 0; contents are don't-care).

Strobe and FIFO rules:
- `set` and `get` are ignored when !hit.
- `set` and `get` asserted together: both take effect independently. `addr` selects one register, so at most one side is affected.
- Each FIFO is a circular buffer with read/write pointers of log2(DEPTH) bits that wrap naturally, plus a count of log2(DEPTH)+1 bits. full = (count == DEPTH), empty = (count == 0).
- Host side:
  - tx pop when tx_valid && tx_ready.
  - rx push when rx_valid && rx_ready.
  - A host push to a full RX FIFO is impossible (rx_ready = 0).

Simultaneous events:
- Push and pop in the same cycle on a non-empty, non-full FIFO: count unchanged, both pointers advance.
- Push and pop in the same cycle on a full FIFO: only the pop is legal, since the push sees full in that cycle. The push is dropped and OVF is set (TX side).
- Push to an empty FIFO and pop attempt in the same cycle: the pop sees empty. It is ignored; for RX, UDF is set.
- CTRL flush in the same cycle as any push or pop: flush wins, and all FIFO counts are 0 afterward.
- CTRL clear in the same cycle as a new overflow/underflow event: clear wins.

## Timing
- Reset (reset == 0 at a rising edge):
  - Both FIFOs empty; OVF = UDF = 0.
  - Outputs after the edge: tx_valid = 0, rx_ready = 1, tx_data = 0 (contents are reset to 0), rdata = STATUS value 8'h02 when addr = BASE+2.
  - Reset mid-transfer discards all buffered bytes. No partial state survives.
- CPU write → tx_valid rises the cycle after the `set` edge (1-cycle latency).
- Host rx push → rx_nonempty and RXDATA are visible 1 cycle later.
- rdata, hit and STATUS are combinational on addr and current state. A pop takes effect at the edge where `get` is sampled high; the next head appears in the following cycle.
- Throughput: one push and one pop per FIFO per cycle.

## Test plan
- Reset with reset = 0 for 2 cycles, then read BASE+2 → rdata = 8'h02; tx_valid = 0; rx_ready = 1.
- Write 8'h11, 8'h22, 8'h33 to 8'hF0 with tx_ready = 0, then raise tx_ready → tx_data = 11, 22, 33 on consecutive cycles, then tx_valid = 0.
- Write 5 bytes to TXDATA with DEPTH = 4 and tx_ready = 0 → STATUS = 8'h11 (full + OVF); the 5th byte never appears on tx_data. Then write 8'h01 to CTRL → STATUS bit4 = 0.
- Host pushes 8'hA5; CPU reads 8'hF1 with `get` → rdata = A5 and STATUS bit2 drops next cycle. A second `get` → rdata = 0 and UDF set (STATUS = 8'h22).
- Fill RX to 4 entries → rx_ready = 0. Then `get` and host push in the same cycle → count stays 4 after rx_ready returns, wrap-around order preserved over 10 bytes.
- Write 8'h02 to CTRL while both FIFOs hold data and tx_ready = 1 → next cycle tx_valid = 0, rx_ready = 1, STATUS = 8'h02. Separately, drop reset mid-stream → same result.
